// File: rtl/enigma_host_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : enigma_host_driver_if
// Purpose  : Request/response handshake bundle between a host and the
//            enigma pin-protocol driver.
// Revision : 1.0 - initial release
// ============================================================================
interface enigma_host_driver_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_cmd;
    logic [4:0] req_data;
    logic       resp_valid;
    logic       resp_ready;
    logic [2:0] resp_cmd;
    logic [4:0] resp_letter;
    logic       resp_err;

    modport master (
        output req_valid, req_cmd, req_data, resp_ready,
        input  req_ready, resp_valid, resp_cmd, resp_letter, resp_err
    );

    modport slave (
        input  req_valid, req_cmd, req_data, resp_ready,
        output req_ready, resp_valid, resp_cmd, resp_letter, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/enigma_host_driver.sv
`default_nettype none
// ============================================================================
// Module   : enigma_host_driver
// Purpose  : Sequences host commands onto the enigma chip pins (setup, strobe,
//            busy/valid wait) and returns one response per request.
// Revision : 1.0 - initial release
// ============================================================================
module enigma_host_driver #(
    parameter int         SETUP_CYCLES  = 1,
    parameter int         STROBE_CYCLES = 2,
    parameter int         TIMEOUT       = 255,
    parameter logic [2:0] ENC_CMD       = 3'd5
) (
    input  logic                clk,
    input  logic                rst,
    enigma_host_driver_if.slave host,
    output logic [7:0]          pin_ui_in,
    output logic [7:0]          pin_uio_in,
    input  logic [7:0]          pin_uo_out,
    output logic                busy
);

    localparam int c_CNT_MAX = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_TMO_W   = $clog2(TIMEOUT + 1);

    localparam logic [c_CNT_W-1:0] c_SETUP_LAST  = c_CNT_W'(SETUP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_STROBE_LAST = c_CNT_W'(STROBE_CYCLES - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST    = c_TMO_W'(TIMEOUT - 1);
    localparam logic [2:0]         c_CMD_RSVD    = 3'd7;
    localparam logic [4:0]         c_LETTER_MAX  = 5'd25;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_sync1;
    logic [1:0]           r_sync2;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [c_TMO_W-1:0]   r_tmo;
    logic [c_TMO_W-1:0]   w_tmo_nxt;
    logic                 r_seen_busy;
    logic                 w_seen_nxt;
    logic [7:0]           r_pin_ui;
    logic [7:0]           w_pin_ui_nxt;
    logic                 r_strobe;
    logic                 w_strobe_nxt;
    logic [2:0]           r_resp_cmd;
    logic [2:0]           w_resp_cmd_nxt;
    logic [4:0]           r_resp_letter;
    logic [4:0]           w_resp_letter_nxt;
    logic                 r_resp_err;
    logic                 w_resp_err_nxt;

    logic                 w_valid_s;
    logic                 w_busy_s;
    logic                 w_is_enc;
    logic                 w_reject;
    logic                 w_done;
    logic                 w_unused_ok;

    // Only out_valid/busy cross into this domain through flops; the letter is
    // taken raw because the chip holds it steady while out_valid is high.
    assign w_valid_s   = r_sync2[1];
    assign w_busy_s    = r_sync2[0];
    assign w_unused_ok = pin_uo_out[5];

    assign w_is_enc = (r_resp_cmd == ENC_CMD);
    assign w_reject = (host.req_cmd == c_CMD_RSVD) ||
                      ((host.req_cmd == ENC_CMD) && (host.req_data > c_LETTER_MAX));
    assign w_done   = r_seen_busy & (w_is_enc ? w_valid_s : ~w_busy_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_sync1       <= '0;
            r_sync2       <= '0;
            r_cnt         <= '0;
            r_tmo         <= '0;
            r_seen_busy   <= 1'b0;
            r_pin_ui      <= '0;
            r_strobe      <= 1'b0;
            r_resp_cmd    <= '0;
            r_resp_letter <= '0;
            r_resp_err    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sync1       <= pin_uo_out[7:6];
            r_sync2       <= r_sync1;
            r_cnt         <= w_cnt_nxt;
            r_tmo         <= w_tmo_nxt;
            r_seen_busy   <= w_seen_nxt;
            r_pin_ui      <= w_pin_ui_nxt;
            r_strobe      <= w_strobe_nxt;
            r_resp_cmd    <= w_resp_cmd_nxt;
            r_resp_letter <= w_resp_letter_nxt;
            r_resp_err    <= w_resp_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_tmo_nxt         = r_tmo;
        w_seen_nxt        = r_seen_busy;
        w_pin_ui_nxt      = r_pin_ui;
        w_resp_cmd_nxt    = r_resp_cmd;
        w_resp_letter_nxt = r_resp_letter;
        w_resp_err_nxt    = r_resp_err;

        case (r_state)
            S_IDLE: begin
                if (host.req_valid) begin
                    w_resp_cmd_nxt    = host.req_cmd;
                    w_resp_letter_nxt = '0;
                    if (w_reject) begin
                        // Rejected requests never touch the pins.
                        w_resp_err_nxt = 1'b1;
                        w_state_nxt    = S_RESP;
                    end else begin
                        w_resp_err_nxt = 1'b0;
                        w_pin_ui_nxt   = {host.req_cmd, host.req_data};
                        w_cnt_nxt      = '0;
                        w_seen_nxt     = 1'b0;
                        w_state_nxt    = S_SETUP;
                    end
                end
            end

            S_SETUP: begin
                if (r_cnt == c_SETUP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_STROBE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_STROBE: begin
                w_seen_nxt = r_seen_busy | w_busy_s;
                if (r_cnt == c_STROBE_LAST) begin
                    w_cnt_nxt   = '0;
                    w_tmo_nxt   = '0;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_WAIT: begin
                w_seen_nxt = r_seen_busy | w_busy_s;
                // Completion is tested first so it beats a coincident timeout.
                if (w_done) begin
                    w_resp_err_nxt    = 1'b0;
                    w_resp_letter_nxt = w_is_enc ? pin_uo_out[4:0] : 5'd0;
                    w_state_nxt       = S_RESP;
                end else if (r_tmo == c_TMO_LAST) begin
                    w_resp_err_nxt    = 1'b1;
                    w_resp_letter_nxt = '0;
                    w_state_nxt       = S_RESP;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end

            S_RESP: begin
                if (host.resp_ready) begin
                    w_pin_ui_nxt = '0;
                    w_state_nxt  = S_IDLE;
                end
            end

            default: begin
                w_pin_ui_nxt = '0;
                w_state_nxt  = S_IDLE;
            end
        endcase

        w_strobe_nxt = (w_state_nxt == S_STROBE);
    end

    assign pin_ui_in        = r_pin_ui;
    assign pin_uio_in       = {7'b0, r_strobe};
    assign busy             = (r_state != S_IDLE);
    assign host.req_ready   = (r_state == S_IDLE);
    assign host.resp_valid  = (r_state == S_RESP);
    assign host.resp_cmd    = r_resp_cmd;
    assign host.resp_letter = r_resp_letter;
    assign host.resp_err    = r_resp_err;

    a_resp_stable : assert property (@(posedge clk) disable iff (rst)
        (host.resp_valid && !host.resp_ready) |=>
            (host.resp_valid && $stable(host.resp_cmd) &&
             $stable(host.resp_letter) && $stable(host.resp_err)));

endmodule
`default_nettype wire

// File: tb/tb_enigma_host_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_enigma_host_driver
// Purpose  : Self-checking bench with a behavioural chip model and a
//            response reference model for enigma_host_driver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enigma_host_driver;

    localparam int         c_SETUP   = 1;
    localparam int         c_STROBE  = 2;
    localparam int         c_TIMEOUT = 255;
    localparam logic [2:0] c_ENC     = 3'd5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pin_ui_in;
    logic [7:0] pin_uio_in;
    logic [7:0] pin_uo_out = 8'h00;
    logic       busy;

    enigma_host_driver_if host_if ();

    enigma_host_driver #(
        .SETUP_CYCLES  (c_SETUP),
        .STROBE_CYCLES (c_STROBE),
        .TIMEOUT       (c_TIMEOUT),
        .ENC_CMD       (c_ENC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .host       (host_if.slave),
        .pin_ui_in  (pin_ui_in),
        .pin_uio_in (pin_uio_in),
        .pin_uo_out (pin_uo_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Chip model: windows are timed from the strobe rising edge.
    int         m_busy_start = 0;
    int         m_busy_len   = 0;
    int         m_valid_start = 0;
    bit         m_valid_on   = 1'b0;
    logic [4:0] m_letter     = 5'd0;
    int         m_k          = 0;
    bit         m_active     = 1'b0;
    logic       m_prev_strobe = 1'b0;
    logic       m_bz;
    logic       m_vl;

    always @(negedge clk) begin
        if (pin_uio_in[0] && !m_prev_strobe) begin
            m_k      = 0;
            m_active = 1'b1;
        end else if (m_active) begin
            m_k = m_k + 1;
            if (m_k > 400) m_active = 1'b0;
        end
        m_prev_strobe = pin_uio_in[0];
        m_bz = m_active && (m_busy_len > 0) && (m_k >= m_busy_start) && (m_k < m_busy_start + m_busy_len);
        m_vl = m_active && m_valid_on && (m_k >= m_valid_start) && (m_k < m_valid_start + 4);
        pin_uo_out = {m_vl, m_bz, 1'b0, m_vl ? m_letter : 5'($urandom)};
    end

    // Reference: what the host should get back for a request and chip behaviour.
    function automatic logic [5:0] ref_resp(input logic [2:0] cmd, input logic [4:0] data,
                                            input int blen, input bit von, input logic [4:0] letter);
        if (cmd == 3'd7 || (cmd == c_ENC && data > 5'd25)) return {1'b1, 5'd0};
        if (blen == 0) return {1'b1, 5'd0};
        if (cmd == c_ENC) return von ? {1'b0, letter} : {1'b1, 5'd0};
        return {1'b0, 5'd0};
    endfunction

    task automatic do_txn(input string tag, input logic [2:0] cmd, input logic [4:0] data,
                          input int bstart, input int blen, input int vstart, input bit von,
                          input logic [4:0] letter, input int hold);
        bit         rej;
        bit         exp_err;
        logic [4:0] exp_letter;
        logic [5:0] r;
        logic [7:0] exp_ui;
        bit         ready_seen;
        bit         ui_ok;
        bit         rdy_ok;
        bit         uio_ok;
        bit         got;
        bit         prev_s;
        int         n_strobe;
        int         n_first;
        int         n_wait;
        int         n_resp;
        logic [2:0] c0;
        logic [4:0] l0;
        logic       e0;

        rej        = (cmd == 3'd7) || (cmd == c_ENC && data > 5'd25);
        r          = ref_resp(cmd, data, blen, von, letter);
        exp_err    = r[5];
        exp_letter = r[4:0];
        exp_ui     = rej ? 8'h00 : {cmd, data};

        @(posedge clk); #1;
        m_active      = 1'b0;
        m_busy_start  = bstart;
        m_busy_len    = blen;
        m_valid_start = vstart;
        m_valid_on    = von;
        m_letter      = letter;
        host_if.req_cmd   = cmd;
        host_if.req_data  = data;
        host_if.req_valid = 1'b1;

        ready_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (host_if.req_ready) begin
                ready_seen = 1'b1;
                break;
            end
        end
        check_eq({tag, " req_ready"}, 32'(ready_seen), 32'd1);
        if (!ready_seen) begin
            host_if.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        host_if.req_valid = 1'b0;

        ui_ok = 1'b1; rdy_ok = 1'b1; uio_ok = 1'b1; got = 1'b0; prev_s = 1'b0;
        n_strobe = 0; n_first = -1; n_wait = -1; n_resp = -1;
        for (int n = 1; n <= c_TIMEOUT + 40; n++) begin
            @(negedge clk);
            if (host_if.req_ready) rdy_ok = 1'b0;
            if (pin_uio_in[7:1] != 7'd0) uio_ok = 1'b0;
            if (pin_ui_in != exp_ui) ui_ok = 1'b0;
            if (host_if.resp_valid) begin
                n_resp = n;
                got    = 1'b1;
                break;
            end
            if (pin_uio_in[0]) begin
                n_strobe++;
                if (n_first < 0) n_first = n;
            end
            if (!pin_uio_in[0] && prev_s && n_wait < 0) n_wait = n;
            prev_s = pin_uio_in[0];
        end
        check_eq({tag, " resp_arrived"}, 32'(got), 32'd1);
        if (!got) return;

        check_eq({tag, " pin_ui_in"}, 32'(ui_ok), 32'd1);
        check_eq({tag, " req_ready_low"}, 32'(rdy_ok), 32'd1);
        check_eq({tag, " uio_upper_zero"}, 32'(uio_ok), 32'd1);
        check_eq({tag, " resp_cmd"}, 32'(host_if.resp_cmd), 32'(cmd));
        check_eq({tag, " resp_letter"}, 32'(host_if.resp_letter), 32'(exp_letter));
        check_eq({tag, " resp_err"}, 32'(host_if.resp_err), 32'(exp_err));
        if (rej) begin
            check_eq({tag, " reject_latency"}, 32'(n_resp), 32'd1);
            check_eq({tag, " reject_no_strobe"}, 32'(n_strobe), 32'd0);
        end else begin
            check_eq({tag, " strobe_cycles"}, 32'(n_strobe), 32'(c_STROBE));
            check_eq({tag, " strobe_start"}, 32'(n_first), 32'(1 + c_SETUP));
            if (exp_err)
                check_eq({tag, " timeout_latency"}, 32'(n_resp - n_wait), 32'(c_TIMEOUT));
        end

        c0 = host_if.resp_cmd; l0 = host_if.resp_letter; e0 = host_if.resp_err;
        for (int h = 0; h < hold; h++) begin
            host_if.req_cmd   = 3'd4;
            host_if.req_data  = 5'd1;
            host_if.req_valid = 1'b1;
            @(negedge clk);
            check_eq({tag, " hold_valid"}, 32'(host_if.resp_valid), 32'd1);
            check_eq({tag, " hold_fields"}, 32'({host_if.resp_cmd, host_if.resp_letter, host_if.resp_err}),
                     32'({c0, l0, e0}));
            check_eq({tag, " hold_req_ready"}, 32'(host_if.req_ready), 32'd0);
        end

        host_if.req_valid  = 1'b0;
        host_if.resp_ready = 1'b1;
        @(posedge clk); #1;
        host_if.resp_ready = 1'b0;
        @(negedge clk);
        check_eq({tag, " after_resp_valid"}, 32'(host_if.resp_valid), 32'd0);
        check_eq({tag, " after_pins"}, 32'({pin_ui_in, pin_uio_in}), 32'd0);
        check_eq({tag, " after_idle"}, 32'({busy, host_if.req_ready}), 32'b01);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic [2:0] cmd;
        logic [4:0] data;
        int         bs;
        int         bl;
        int         vs;
        bit         von;
        bit         seen;

        host_if.req_valid  = 1'b0;
        host_if.req_cmd    = 3'd0;
        host_if.req_data   = 5'd0;
        host_if.resp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("reset ready_valid", 32'({host_if.req_ready, host_if.resp_valid}), 32'b10);
        check_eq("reset resp_fields", 32'({host_if.resp_cmd, host_if.resp_letter, host_if.resp_err}), 32'd0);
        check_eq("reset pins_busy", 32'({pin_ui_in, pin_uio_in, busy}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed scenarios
        do_txn("enc_A",     c_ENC, 5'd0,  1, 1, 4, 1'b1, 5'd9, 0);
        do_txn("load_pos",  3'd1,  5'd17, 1, 3, 0, 1'b0, 5'd0, 1);
        do_txn("enc_bad",   c_ENC, 5'd26, 1, 2, 5, 1'b1, 5'd3, 0);
        do_txn("cmd7",      3'd7,  5'd4,  1, 2, 5, 1'b1, 5'd3, 0);
        do_txn("silent",    3'd2,  5'd8,  0, 0, 0, 1'b0, 5'd0, 0);
        do_txn("nop_pulse", 3'd0,  5'd0,  2, 2, 0, 1'b0, 5'd0, 0);
        do_txn("enc_hold",  c_ENC, 5'd25, 0, 2, 3, 1'b1, 5'd17, 10);

        // Reset while strobing
        @(posedge clk); #1;
        m_active = 1'b0; m_busy_start = 1; m_busy_len = 2; m_valid_start = 4; m_valid_on = 1'b1; m_letter = 5'd6;
        host_if.req_cmd = c_ENC; host_if.req_data = 5'd3; host_if.req_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        host_if.req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pin_uio_in[0]) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("rst_mid strobe_seen", 32'(seen), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_mid pins", 32'({pin_ui_in, pin_uio_in}), 32'd0);
        check_eq("rst_mid state", 32'({host_if.resp_valid, busy, host_if.req_ready}), 32'b001);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        do_txn("post_rst", c_ENC, 5'd12, 1, 1, 3, 1'b1, 5'd21, 2);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            cmd  = 3'($urandom_range(0, 7));
            data = ($urandom_range(0, 99) < 85) ? 5'($urandom_range(0, 25)) : 5'($urandom_range(26, 31));
            if ($urandom_range(0, 15) == 0) begin
                bs = 0; bl = 0; vs = 0; von = 1'b0;
            end else begin
                bs  = $urandom_range(0, 4);
                bl  = $urandom_range(1, 3);
                vs  = bs + bl + $urandom_range(0, 3);
                von = (cmd == c_ENC) ? ($urandom_range(0, 9) != 0) : 1'b0;
            end
            do_txn($sformatf("rand%0d", t), cmd, data, bs, bl, vs, von,
                   5'($urandom_range(0, 25)), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
